// File: rtl/lbp_fetch_ctrl_if.sv
// Bus between the LBP fetch sequencer, the host gray memory and the LBP datapath stage.
// Handshake: gray_req_o is a one-cycle read strobe with no back-pressure; gray_data_i answers in the following cycle.
interface lbp_fetch_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              gray_ready_i;
  logic              gray_req_o;
  logic [ADDR_W-1:0] gray_addr_o;
  logic [7:0]        gray_data_i;
  logic [7:0]        graydata_o;
  logic [3:0]        cnt_o;
  logic              white_o;
  logic [ADDR_W-1:0] addr_o;
  logic              lbp_valid_o;
  logic              finish_o;
  logic [1:0]        dbg_state_o;

  modport master (
    input  gray_ready_i, gray_data_i,
    output gray_req_o, gray_addr_o, graydata_o, cnt_o, white_o, addr_o,
           lbp_valid_o, finish_o, dbg_state_o
  );

  modport slave (
    output gray_ready_i, gray_data_i,
    input  gray_req_o, gray_addr_o, graydata_o, cnt_o, white_o, addr_o,
           lbp_valid_o, finish_o, dbg_state_o
  );
endinterface

// File: rtl/lbp_fetch_ctrl.sv
// Raster-order fetch sequencer for the LBP stage: issues centre + 8 neighbour reads per interior
// pixel, one dummy slot per border pixel, and aligns step/border/address tags with returned data.
module lbp_fetch_ctrl #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  lbp_fetch_ctrl_if.master bus
);
  localparam int                COL_W = ADDR_W / 2;
  localparam logic [COL_W-1:0]  EDGE  = COL_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_W:0]   pix_q, pix_d;
  logic [3:0]        step_q, step_d;

  // Issue stage: what is on the memory bus this cycle, plus the tags travelling with it.
  logic              req_q, req_d;
  logic [ADDR_W-1:0] gaddr_q, gaddr_d;
  logic              iss_vld_q, iss_vld_d;
  logic [3:0]        iss_cnt_q, iss_cnt_d;
  logic              iss_white_q, iss_white_d;
  logic [ADDR_W-1:0] iss_pix_q, iss_pix_d;
  logic              iss_last_q, iss_last_d;
  logic              iss_final_q, iss_final_d;

  // Presentation stage: aligned with gray_data_i returning from memory.
  logic [3:0]        cnt_q, cnt_d;
  logic              white_q, white_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pre_last_q, pre_last_d;
  logic              pre_final_q, pre_final_d;
  logic              lbp_valid_q, lbp_valid_d;
  logic              val_final_q, val_final_d;
  logic              finish_q, finish_d;

  logic              issue;
  logic [ADDR_W-1:0] cur_pix;
  logic [COL_W-1:0]  row, col;
  logic              border;
  logic              slot_last;
  logic [ADDR_W-1:0] nb_addr;

  always_comb begin
    cur_pix   = pix_q[ADDR_W-1:0];
    row       = cur_pix[ADDR_W-1:COL_W];
    col       = cur_pix[COL_W-1:0];
    border    = (row == '0) || (row == EDGE) || (col == '0) || (col == EDGE);
    slot_last = border || (step_q == 4'd8);
    // pix_q is always 0 in IDLE, so the first slot can issue on the same edge that leaves IDLE.
    issue     = ((state_q == IDLE) && bus.gray_ready_i) ||
                ((state_q == RUN) && !pix_q[ADDR_W]);

    case (step_q)
      4'd0:    nb_addr = cur_pix;
      4'd1:    nb_addr = cur_pix - ROW - ONE;
      4'd2:    nb_addr = cur_pix - ROW;
      4'd3:    nb_addr = cur_pix - ROW + ONE;
      4'd4:    nb_addr = cur_pix - ONE;
      4'd5:    nb_addr = cur_pix + ONE;
      4'd6:    nb_addr = cur_pix + ROW - ONE;
      4'd7:    nb_addr = cur_pix + ROW;
      default: nb_addr = cur_pix + ROW + ONE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    step_d      = step_q;
    req_d       = 1'b0;
    gaddr_d     = gaddr_q;
    iss_vld_d   = 1'b0;
    iss_cnt_d   = 4'd0;
    iss_white_d = 1'b0;
    iss_pix_d   = iss_pix_q;
    iss_last_d  = 1'b0;
    iss_final_d = 1'b0;

    if (issue) begin
      req_d       = !border;
      iss_vld_d   = 1'b1;
      iss_cnt_d   = border ? 4'd0 : step_q;
      iss_white_d = border;
      iss_pix_d   = cur_pix;
      iss_last_d  = slot_last;
      iss_final_d = slot_last && (cur_pix == {ADDR_W{1'b1}});
      if (!border) gaddr_d = nb_addr;
      if (slot_last) begin
        pix_d  = pix_q + (ADDR_W+1)'(1);
        step_d = 4'd0;
      end else begin
        step_d = step_q + 4'd1;
      end
    end

    cnt_d       = iss_cnt_q;
    white_d     = iss_white_q;
    addr_d      = iss_vld_q ? iss_pix_q : addr_q;
    pre_last_d  = iss_last_q;
    pre_final_d = iss_final_q;
    lbp_valid_d = pre_last_q;
    val_final_d = pre_final_q;
    finish_d    = finish_q || (lbp_valid_q && val_final_q);

    case (state_q)
      IDLE:    if (bus.gray_ready_i) state_d = RUN;
      RUN:     if (lbp_valid_q && val_final_q) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      step_q      <= 4'd0;
      req_q       <= 1'b0;
      gaddr_q     <= '0;
      iss_vld_q   <= 1'b0;
      iss_cnt_q   <= 4'd0;
      iss_white_q <= 1'b0;
      iss_pix_q   <= '0;
      iss_last_q  <= 1'b0;
      iss_final_q <= 1'b0;
      cnt_q       <= 4'd0;
      white_q     <= 1'b0;
      addr_q      <= '0;
      pre_last_q  <= 1'b0;
      pre_final_q <= 1'b0;
      lbp_valid_q <= 1'b0;
      val_final_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      step_q      <= step_d;
      req_q       <= req_d;
      gaddr_q     <= gaddr_d;
      iss_vld_q   <= iss_vld_d;
      iss_cnt_q   <= iss_cnt_d;
      iss_white_q <= iss_white_d;
      iss_pix_q   <= iss_pix_d;
      iss_last_q  <= iss_last_d;
      iss_final_q <= iss_final_d;
      cnt_q       <= cnt_d;
      white_q     <= white_d;
      addr_q      <= addr_d;
      pre_last_q  <= pre_last_d;
      pre_final_q <= pre_final_d;
      lbp_valid_q <= lbp_valid_d;
      val_final_q <= val_final_d;
      finish_q    <= finish_d;
    end
  end

  assign bus.gray_req_o  = req_q;
  assign bus.gray_addr_o = gaddr_q;
  assign bus.graydata_o  = bus.gray_data_i;
  assign bus.cnt_o       = cnt_q;
  assign bus.white_o     = white_q;
  assign bus.addr_o      = addr_q;
  assign bus.lbp_valid_o = lbp_valid_q;
  assign bus.finish_o    = finish_q;
  assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_lbp_fetch_ctrl.sv
// Bench for lbp_fetch_ctrl on a 16x16 image: per-cycle slot model, memory model, LBP golden compare,
// mid-frame reset and gray_ready_i noise.
module tb_lbp_fetch_ctrl;
  localparam int W    = 16;
  localparam int AW   = 8;
  localparam int N    = W * W;
  localparam int NINT = (W - 2) * (W - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lbp_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  lbp_fetch_ctrl #(.IMG_W(W), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit req;
    int gaddr;
    int cnt;
    bit white;
    int pix;
    bit last;
  } slot_t;

  slot_t      slots[$];
  logic [7:0] mem[N];
  int         dp_res[N];
  int         dr[9] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
  int         dc[9] = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
  int         n_checks = 0;
  int         n_fail = 0;
  int         dp_acc, dp_center, dp_pulses, req_cycles, prev_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Expected issue slots for one frame, straight from the raster/neighbour rules.
  task automatic build_slots();
    int    held = 0;
    slot_t s;
    slots.delete();
    for (int p = 0; p < N; p++) begin
      int r = p / W;
      int c = p % W;
      if (r == 0 || r == W - 1 || c == 0 || c == W - 1) begin
        s.req = 0; s.gaddr = held; s.cnt = 0; s.white = 1; s.pix = p; s.last = 1;
        slots.push_back(s);
      end else begin
        for (int i = 0; i < 9; i++) begin
          held = (r + dr[i]) * W + (c + dc[i]);
          s.req = 1; s.gaddr = held; s.cnt = i; s.white = 0; s.pix = p; s.last = (i == 8);
          slots.push_back(s);
        end
      end
    end
  endtask

  function automatic int lbp_gold(input int p);
    int r = p / W;
    int c = p % W;
    int v = 0;
    if (r == 0 || r == W - 1 || c == 0 || c == W - 1) return 0;
    for (int i = 1; i < 9; i++)
      if (mem[(r + dr[i]) * W + c + dc[i]] >= mem[p]) v |= (1 << (i - 1));
    return v;
  endfunction

  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_gray_req",  32'(bus.gray_req_o),  0);
    check_eq("rst_gray_addr", 32'(bus.gray_addr_o), 0);
    check_eq("rst_cnt",       32'(bus.cnt_o),       0);
    check_eq("rst_white",     32'(bus.white_o),     0);
    check_eq("rst_addr",      32'(bus.addr_o),      0);
    check_eq("rst_lbp_valid", 32'(bus.lbp_valid_o), 0);
    check_eq("rst_finish",    32'(bus.finish_o),    0);
    bus.gray_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle_check(input int ncyc);
    bus.gray_ready_i = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      check_eq("idle_req",    32'(bus.gray_req_o),  0);
      check_eq("idle_valid",  32'(bus.lbp_valid_o), 0);
      check_eq("idle_finish", 32'(bus.finish_o),    0);
    end
  endtask

  // Cycle t counts from the first issue cycle of the frame.
  task automatic check_cycle(input int t);
    int S = slots.size();
    bit lbp_exp;
    if (t < S) begin
      check_eq("gray_req",  32'(bus.gray_req_o),  32'(slots[t].req));
      check_eq("gray_addr", 32'(bus.gray_addr_o), slots[t].gaddr);
    end else begin
      check_eq("gray_req_tail",  32'(bus.gray_req_o),  0);
      check_eq("gray_addr_tail", 32'(bus.gray_addr_o), slots[S-1].gaddr);
    end
    if (t >= 1 && t <= S) begin
      check_eq("cnt",   32'(bus.cnt_o),   slots[t-1].cnt);
      check_eq("white", 32'(bus.white_o), 32'(slots[t-1].white));
      check_eq("addr",  32'(bus.addr_o),  slots[t-1].pix);
      if (slots[t-1].req) check_eq("graydata", 32'(bus.graydata_o), 32'(mem[slots[t-1].gaddr]));
    end else begin
      check_eq("cnt_idle",   32'(bus.cnt_o),   0);
      check_eq("white_idle", 32'(bus.white_o), 0);
      check_eq("addr_hold",  32'(bus.addr_o),  (t == 0) ? 0 : N - 1);
    end
    lbp_exp = (t >= 2) && (t - 2 < S) && slots[t-2].last;
    check_eq("lbp_valid", 32'(bus.lbp_valid_o), 32'(lbp_exp));
    check_eq("finish",    32'(bus.finish_o),    32'(t >= S + 2));

    // Bench-side LBP datapath driven only by the DUT's presented stream.
    if (bus.lbp_valid_o) begin
      dp_res[prev_addr] = dp_acc;
      dp_pulses++;
    end
    if (t >= 1 && t <= S) begin
      if (bus.white_o) dp_acc = 0;
      else if (bus.cnt_o == 4'd0) begin
        dp_center = int'(bus.graydata_o);
        dp_acc = 0;
      end else if (int'(bus.graydata_o) >= dp_center) dp_acc |= (1 << (int'(bus.cnt_o) - 1));
    end
    prev_addr = int'(bus.addr_o);
    if (bus.gray_req_o) req_cycles++;
  endtask

  task automatic run_frame(input int abort_at, input bit low_entropy);
    int S = slots.size();
    dp_pulses = 0; req_cycles = 0; dp_acc = 0; dp_center = 0; prev_addr = 0;
    for (int i = 0; i < N; i++) begin
      mem[i] = low_entropy ? 8'($urandom_range(0, 3)) : 8'($urandom);
      dp_res[i] = -1;
    end
    @(negedge clk);
    bus.gray_ready_i = 1'b1;
    for (int t = 0; t < S + 6; t++) begin
      @(negedge clk);
      check_cycle(t);
      bus.gray_data_i  = bus.gray_req_o ? mem[bus.gray_addr_o] : 8'($urandom);
      bus.gray_ready_i = 1'($urandom_range(0, 1));
      if (t == abort_at) begin
        apply_reset();
        return;
      end
    end
    check_eq("lbp_pulses", dp_pulses,  N);
    check_eq("req_cycles", req_cycles, NINT * 9);
    for (int p = 0; p < N; p++) check_eq("lbp_result", dp_res[p], lbp_gold(p));
    bus.gray_ready_i = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_eq("done_finish", 32'(bus.finish_o),    1);
      check_eq("done_req",    32'(bus.gray_req_o),  0);
      check_eq("done_valid",  32'(bus.lbp_valid_o), 0);
      check_eq("done_addr",   32'(bus.addr_o),      N - 1);
    end
  endtask

  initial begin
    int p_abort;
    int abort_at;
    bus.gray_ready_i = 1'b0;
    bus.gray_data_i  = 8'h00;
    build_slots();

    @(negedge clk);
    apply_reset();
    idle_check($urandom_range(3, 10));
    run_frame(-1, 1'b0);

    apply_reset();
    idle_check($urandom_range(3, 10));
    p_abort  = $urandom_range(1, W - 2) * W + $urandom_range(1, W - 2);
    abort_at = -1;
    foreach (slots[i]) if (slots[i].pix == p_abort && slots[i].cnt == 5) abort_at = i;
    run_frame(abort_at, 1'b0);

    idle_check($urandom_range(3, 10));
    run_frame(-1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lbp_fetch_ctrl.md
Name: lbp_fetch_ctrl

Overview:
- Upstream sequencer for the LBP datapath stage.
- Walks a 128x128 gray image in raster order and issues synchronous reads to the host gray memory: the centre pixel first, then its 8 neighbours.
- Presents each returned byte to the LBP datapath stage with its step index, border flag and centre-pixel address.
- Generates the per-pixel result-valid strobe and the end-of-frame finish flag.

Parameters:
IMG_W, 128, image width and height in pixels (power of 2)
ADDR_W, 14, pixel address width; 2^ADDR_W == IMG_W*IMG_W

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (asserted when 0)
gray_ready_i  input  1  host image-ready level; starts a frame
gray_req_o  output  1  gray memory read enable
gray_addr_o  output  ADDR_W  gray memory read address
gray_data_i  input  8  gray memory read data, valid the cycle after gray_req_o
graydata_o  output  8  byte to datapath; combinational pass-through of gray_data_i
cnt_o  output  4  step index: 0 = centre, 1..8 = neighbour
white_o  output  1  current pixel is a border pixel
addr_o  output  ADDR_W  centre pixel address, held for all steps of a pixel
lbp_valid_o  output  1  one-cycle pulse; datapath result for the previous pixel is complete
finish_o  output  1  frame done; sticky until reset

Behaviour:
- Reset (rst=0, async): state IDLE, pixel counter 0, step 0. All registered outputs are 0: gray_req_o, gray_addr_o, cnt_o, white_o, addr_o, lbp_valid_o, finish_o.
- IDLE: wait for gray_ready_i=1 sampled at a clock edge, then go to RUN with pixel p=0.
- DONE: entered after the final lbp_valid_o. finish_o=1; no further reads; gray_ready_i is ignored until reset.
- Pixel p is at row r=p/IMG_W, col c=p%IMG_W.
- Border pixel: r==0, r==IMG_W-1, c==0 or c==IMG_W-1.
- Border pixel in RUN:
  - occupies one issue slot
  - gray_req_o=0; gray_addr_o holds its previous value
  - the presented slot carries cnt_o=0, white_o=1
- Interior pixel in RUN:
  - occupies 9 consecutive issue slots, gray_req_o=1 in each
  - gray_addr_o sequence: p, p-IMG_W-1, p-IMG_W, p-IMG_W+1, p-1, p+1, p+IMG_W-1, p+IMG_W, p+IMG_W+1
  - presented cnt_o=0..8 in the same order, white_o=0
  - no address wrap can occur, because only interior pixels fetch neighbours
- Pipeline alignment:
  - A slot issued in cycle k is presented in cycle k+1: cnt_o, white_o and addr_o are registered; graydata_o=gray_data_i in that same cycle.
  - A presented slot with no issue behind it drives cnt_o=0, white_o=0 and keeps addr_o.
- Back-to-back: the next pixel's first slot issues in the cycle directly after the current pixel's last slot. There are no bubbles between pixels.
- lbp_valid_o is 1 in cycle k+2, where k is the issue cycle of the pixel's last slot (cnt 8, or the single border slot). addr_o in the preceding cycle equals that pixel's address.
- Frame length: 508 border slots plus 15876 interior pixels x 9 slots gives 143392 issue slots.
- The lbp_valid_o pulse for p=IMG_W*IMG_W-1 is followed by finish_o=1 in the next cycle.
- Counters: a pixel counter of ADDR_W+1 bits and a 4-bit step counter. The step counter resets to 0 at each pixel start.
- Reset mid-frame: abort immediately and return to IDLE with all outputs 0. A new frame starts from p=0 on the next gray_ready_i.
- gray_ready_i changes while in RUN are ignored.

Test Plan:
- Reset then gray_ready_i=1 -> p=0 slot issues with gray_req_o=0; next cycle white_o=1, cnt_o=0, addr_o=0; lbp_valid_o pulses 2 cycles after issue.
- Pixel 129 (first interior) -> issue starts 129 cycles after RUN entry; gray_addr_o = 129,0,1,2,128,130,256,257,258 on consecutive cycles; cnt_o 0..8 one cycle later with addr_o=129; graydata_o tracks gray_data_i.
- Transition from pixel 254 (interior) to 255 (border, c=127) -> 255 issues with gray_req_o=0 directly after 254's cnt-8 slot; one lbp_valid_o pulse per pixel, with no gap or overlap.
- Full frame with memory model -> exactly 16384 lbp_valid_o pulses, 143392 issue slots; finish_o=1 one cycle after the last pulse and held; an LBP golden-model compare through the datapath stage matches.
- rst=0 during pixel 300 step 5 -> all outputs 0 asynchronously; after release and gray_ready_i=1, sequence restarts at p=0.
- gray_ready_i toggled during RUN, or held after finish -> no change to sequence or to finish_o.
